// File: rtl/fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory read port, redirect request and the
// valid/ready fetch stream toward decode, with the queue occupancy.
interface fetch_unit_if #(
   parameter int XLEN     = 32,
   parameter int IMEM_AW  = 13,
   parameter int FQ_DEPTH = 4
);
   localparam int CW = $clog2(FQ_DEPTH + 1);

   logic               imem_en;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic               redirect_valid;
   logic [XLEN-1:0]    redirect_pc;
   logic               fetch_valid;
   logic [XLEN-1:0]    fetch_pc;
   logic [31:0]        fetch_instr;
   logic               fetch_ready;
   logic [CW-1:0]      fq_count;

   modport master (
      output imem_en, imem_addr, fetch_valid, fetch_pc, fetch_instr, fq_count,
      input  imem_rdata, redirect_valid, redirect_pc, fetch_ready
   );

   modport slave (
      input  imem_en, imem_addr, fetch_valid, fetch_pc, fetch_instr, fq_count,
      output imem_rdata, redirect_valid, redirect_pc, fetch_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Decoupled RV32 fetch front end: credit-gated IMEM issue, in-flight tracking across
// a fixed read latency, and a show-ahead fetch queue with redirect squash.
module fetch_unit_chk #(
   parameter int FQ_DEPTH = 4,
   parameter int CW       = 3
) (
   input logic          clk,
   input logic          rst,
   input logic          push,
   input logic [CW-1:0] count
);
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      push |-> (count != CW'(FQ_DEPTH)));

   a_count_range: assert property (@(posedge clk) disable iff (rst)
      count <= CW'(FQ_DEPTH));
endmodule

module fetch_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = {XLEN{1'b0}},
   parameter int              IMEM_AW      = 13,
   parameter int              IMEM_LATENCY = 1,
   parameter int              FQ_DEPTH     = 4
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master fu
);
   localparam int              LAT     = IMEM_LATENCY;
   localparam int              CW      = $clog2(FQ_DEPTH + 1);
   localparam int              PW      = $clog2(FQ_DEPTH);
   localparam int              SW      = $clog2(FQ_DEPTH + IMEM_LATENCY + 1);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic [LAT-1:0]  infl_vld_q, infl_vld_d;
   logic [XLEN-1:0] infl_pc_q [LAT];
   logic [XLEN-1:0] infl_pc_d [LAT];
   logic [XLEN-1:0] fq_pc_q [FQ_DEPTH];
   logic [XLEN-1:0] fq_pc_d [FQ_DEPTH];
   logic [31:0]     fq_instr_q [FQ_DEPTH];
   logic [31:0]     fq_instr_d [FQ_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic [SW-1:0]   inflight;
   logic [SW-1:0]   credit_used;
   logic            head_valid;
   logic            issue;
   logic            push;
   logic            pop;
   logic            unused_redirect_lsb;

   // Credit check: queued plus in-flight words must leave room; a same-cycle pop earns nothing.
   always_comb begin
      inflight = {SW{1'b0}};
      for (int i = 0; i < LAT; i++) begin
         inflight = inflight + SW'(infl_vld_q[i]);
      end
      credit_used = SW'(count_q) + inflight;
      head_valid  = (count_q != {CW{1'b0}});
      issue       = !rst && !fu.redirect_valid && (credit_used < SW'(FQ_DEPTH));
      push        = infl_vld_q[LAT-1];
      pop         = head_valid && fu.fetch_ready;
   end

   // Next-state for request PC, in-flight pipe and queue; redirect squashes everything.
   always_comb begin
      req_pc_d   = req_pc_q;
      infl_vld_d = infl_vld_q;
      infl_pc_d  = infl_pc_q;
      fq_pc_d    = fq_pc_q;
      fq_instr_d = fq_instr_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (fu.redirect_valid) begin
         req_pc_d   = {fu.redirect_pc[XLEN-1:2], 2'b00};
         infl_vld_d = {LAT{1'b0}};
         wr_ptr_d   = {PW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         count_d    = {CW{1'b0}};
      end else begin
         if (issue) begin
            req_pc_d = req_pc_q + PC_STEP;
         end else begin
            req_pc_d = req_pc_q;
         end

         infl_vld_d[0] = issue;
         infl_pc_d[0]  = req_pc_q;
         for (int i = 1; i < LAT; i++) begin
            infl_vld_d[i] = infl_vld_q[i-1];
            infl_pc_d[i]  = infl_pc_q[i-1];
         end

         if (push) begin
            fq_pc_d[wr_ptr_q]    = infl_pc_q[LAT-1];
            fq_instr_d[wr_ptr_q] = fu.imem_rdata;
            wr_ptr_d             = wr_ptr_q + PW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state with synchronous reset to the reset vector and an empty pipe/queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_pc_q   <= RESET_PC;
         infl_vld_q <= {LAT{1'b0}};
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
      end else begin
         req_pc_q   <= req_pc_d;
         infl_vld_q <= infl_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Datapath storage; contents are qualified by the valid bits and count, so no reset.
   always_ff @(posedge clk) begin
      infl_pc_q  <= infl_pc_d;
      fq_pc_q    <= fq_pc_d;
      fq_instr_q <= fq_instr_d;
   end

   assign fu.imem_en     = issue;
   assign fu.imem_addr   = req_pc_q[IMEM_AW+1:2];
   assign fu.fetch_valid = head_valid;
   assign fu.fetch_pc    = head_valid ? fq_pc_q[rd_ptr_q] : {XLEN{1'b0}};
   assign fu.fetch_instr = head_valid ? fq_instr_q[rd_ptr_q] : 32'h0000_0000;
   assign fu.fq_count    = count_q;

   assign unused_redirect_lsb = ^fu.redirect_pc[1:0];

   fetch_unit_chk #(
      .FQ_DEPTH (FQ_DEPTH),
      .CW       (CW)
   ) u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .count (count_q)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-1/depth-4 instance and a latency-3/depth-8
// instance, each fed by a synchronous IMEM model returning addr*4+0x13.
`timescale 1ns/1ps
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fetch_unit_if #(.XLEN(32), .IMEM_AW(13), .FQ_DEPTH(4)) f1 ();
   fetch_unit_if #(.XLEN(32), .IMEM_AW(13), .FQ_DEPTH(8)) f3 ();

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .IMEM_AW(13),
                .IMEM_LATENCY(1), .FQ_DEPTH(4)) dut1 (.clk(clk), .rst(rst), .fu(f1.master));
   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_1000), .IMEM_AW(13),
                .IMEM_LATENCY(3), .FQ_DEPTH(8)) dut3 (.clk(clk), .rst(rst), .fu(f3.master));

   function automatic logic [31:0] imem_word(input logic [12:0] a);
      return {17'b0, a, 2'b00} + 32'h0000_0013;
   endfunction

   logic [31:0] m1;
   logic [31:0] m3 [3];

   always @(posedge clk) begin
      m1    <= f1.imem_en ? imem_word(f1.imem_addr) : 32'hDEAD_BEEF;
      m3[0] <= f3.imem_en ? imem_word(f3.imem_addr) : 32'hDEAD_BEEF;
      m3[1] <= m3[0];
      m3[2] <= m3[1];
   end
   assign f1.imem_rdata = m1;
   assign f3.imem_rdata = m3[2];

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      f1.redirect_valid = 1'b0; f1.redirect_pc = 32'h0; f1.fetch_ready = 1'b0;
      f3.redirect_valid = 1'b0; f3.redirect_pc = 32'h0; f3.fetch_ready = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({f1.fetch_valid, f1.fq_count, f1.imem_en} !== {1'b0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state valid=%b count=%0d en=%b expected 0/0/0",
                  f1.fetch_valid, f1.fq_count, f1.imem_en);
      end
      checks++;
      if ({f1.fetch_pc, f1.fetch_instr} !== 64'h0) begin
         errors++;
         $display("FAIL reset_data pc=%h instr=%h expected 0/0", f1.fetch_pc, f1.fetch_instr);
      end
      checks++;
      if ({f3.fetch_valid, f3.fq_count, f3.imem_en} !== {1'b0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state3 valid=%b count=%0d en=%b expected 0/0/0",
                  f3.fetch_valid, f3.fq_count, f3.imem_en);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({f1.imem_en, f1.imem_addr, f3.imem_en, f3.imem_addr} !== {1'b1, 13'h000, 1'b1, 13'h400}) begin
         errors++;
         $display("FAIL t0_issue en1=%b addr1=%h en3=%b addr3=%h expected 1/000/1/400",
                  f1.imem_en, f1.imem_addr, f3.imem_en, f3.imem_addr);
      end
   endtask

   task automatic test_stream(inout logic [31:0] exp);
      do_reset();
      rst = 1'b0;
      f1.fetch_ready = 1'b1;
      tick();
      checks++;
      if (f1.fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_t1 valid=%b expected 0", f1.fetch_valid);
      end
      tick();
      exp = 32'h0;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({f1.fetch_valid, f1.fetch_pc, f1.fetch_instr} !== {1'b1, exp, exp + 32'h13}) begin
            errors++;
            $display("FAIL stream[%0d] valid=%b pc=%h instr=%h expected pc=%h instr=%h",
                     k, f1.fetch_valid, f1.fetch_pc, f1.fetch_instr, exp, exp + 32'h13);
         end
         exp = exp + 32'h4;
         tick();
      end
   endtask

   task automatic test_backpressure(input logic [31:0] start);
      logic [31:0] exp;
      exp = start;
      f1.fetch_ready = 1'b0;
      repeat (10) tick();
      checks++;
      if ({f1.fq_count, f1.imem_en, f1.fetch_valid, f1.fetch_pc} !== {3'd4, 1'b0, 1'b1, exp}) begin
         errors++;
         $display("FAIL bp_full count=%0d en=%b valid=%b pc=%h expected 4/0/1/%h",
                  f1.fq_count, f1.imem_en, f1.fetch_valid, f1.fetch_pc, exp);
      end
      f1.fetch_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if ({f1.fetch_valid, f1.fetch_pc, f1.fetch_instr} !== {1'b1, exp, exp + 32'h13}) begin
            errors++;
            $display("FAIL bp_resume[%0d] valid=%b pc=%h instr=%h expected pc=%h",
                     k, f1.fetch_valid, f1.fetch_pc, f1.fetch_instr, exp);
         end
         exp = exp + 32'h4;
         tick();
      end
   endtask

   task automatic test_redirect();
      logic [31:0] exp;
      do_reset();
      rst = 1'b0;
      repeat (4) tick();
      checks++;
      if ({f1.fq_count, f1.imem_en} !== {3'd3, 1'b0}) begin
         errors++;
         $display("FAIL redir_pre count=%0d en=%b expected 3/0", f1.fq_count, f1.imem_en);
      end
      f1.redirect_valid = 1'b1;
      f1.redirect_pc = 32'h0000_0100;
      tick();
      f1.redirect_valid = 1'b0;
      checks++;
      if ({f1.fetch_valid, f1.fq_count} !== {1'b0, 3'd0}) begin
         errors++;
         $display("FAIL redir_flush valid=%b count=%0d expected 0/0", f1.fetch_valid, f1.fq_count);
      end
      f1.fetch_ready = 1'b1;
      #1;
      checks++;
      if ({f1.imem_en, f1.imem_addr} !== {1'b1, 13'h040}) begin
         errors++;
         $display("FAIL redir_issue en=%b addr=%h expected 1/040", f1.imem_en, f1.imem_addr);
      end
      tick();
      checks++;
      if (f1.fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_gap valid=%b expected 0", f1.fetch_valid);
      end
      tick();
      exp = 32'h100;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({f1.fetch_valid, f1.fetch_pc, f1.fetch_instr} !== {1'b1, exp, exp + 32'h13}) begin
            errors++;
            $display("FAIL redir_stream[%0d] valid=%b pc=%h instr=%h expected pc=%h",
                     k, f1.fetch_valid, f1.fetch_pc, f1.fetch_instr, exp);
         end
         exp = exp + 32'h4;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      do_reset();
      rst = 1'b0;
      f3.fetch_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if (f3.fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL l3_t3 valid=%b expected 0", f3.fetch_valid);
      end
      tick();
      checks++;
      if ({f3.fetch_valid, f3.fetch_pc, f3.fetch_instr} !== {1'b1, 32'h1000, 32'h1013}) begin
         errors++;
         $display("FAIL l3_first valid=%b pc=%h instr=%h expected 1/1000/1013",
                  f3.fetch_valid, f3.fetch_pc, f3.fetch_instr);
      end
      tick();
      tick();
      f3.redirect_valid = 1'b1;
      f3.redirect_pc = 32'h0000_0200;
      tick();
      f3.redirect_pc = 32'h0000_0300;
      tick();
      f3.redirect_valid = 1'b0;
      checks++;
      if ({f3.fetch_valid, f3.fq_count} !== {1'b0, 4'd0}) begin
         errors++;
         $display("FAIL b2b_flush valid=%b count=%0d expected 0/0", f3.fetch_valid, f3.fq_count);
      end
      #1;
      checks++;
      if ({f3.imem_en, f3.imem_addr} !== {1'b1, 13'h0C0}) begin
         errors++;
         $display("FAIL b2b_issue en=%b addr=%h expected 1/0c0", f3.imem_en, f3.imem_addr);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (f3.fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap[%0d] valid=%b pc=%h expected 0", k, f3.fetch_valid, f3.fetch_pc);
         end
      end
      tick();
      exp = 32'h300;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if ({f3.fetch_valid, f3.fetch_pc, f3.fetch_instr} !== {1'b1, exp, exp + 32'h13}) begin
            errors++;
            $display("FAIL b2b_stream[%0d] valid=%b pc=%h instr=%h expected pc=%h",
                     k, f3.fetch_valid, f3.fetch_pc, f3.fetch_instr, exp);
         end
         exp = exp + 32'h4;
         tick();
      end
   endtask

   task automatic test_redirect_pop();
      do_reset();
      rst = 1'b0;
      f1.fetch_ready = 1'b1;
      repeat (3) tick();
      checks++;
      if ({f1.fetch_valid, f1.fetch_pc} !== {1'b1, 32'h4}) begin
         errors++;
         $display("FAIL rpop_pre valid=%b pc=%h expected 1/4", f1.fetch_valid, f1.fetch_pc);
      end
      f1.redirect_valid = 1'b1;
      f1.redirect_pc = 32'h0000_0102;
      tick();
      f1.redirect_valid = 1'b0;
      checks++;
      if ({f1.fetch_valid, f1.fq_count, f1.imem_addr} !== {1'b0, 3'd0, 13'h040}) begin
         errors++;
         $display("FAIL rpop_flush valid=%b count=%0d addr=%h expected 0/0/040",
                  f1.fetch_valid, f1.fq_count, f1.imem_addr);
      end
      tick();
      tick();
      checks++;
      if ({f1.fetch_valid, f1.fetch_pc, f1.fetch_instr} !== {1'b1, 32'h100, 32'h113}) begin
         errors++;
         $display("FAIL rpop_first valid=%b pc=%h instr=%h expected 1/100/113",
                  f1.fetch_valid, f1.fetch_pc, f1.fetch_instr);
      end
      tick();
      checks++;
      if ({f1.fetch_valid, f1.fetch_pc} !== {1'b1, 32'h104}) begin
         errors++;
         $display("FAIL rpop_second valid=%b pc=%h expected 1/104", f1.fetch_valid, f1.fetch_pc);
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      rst = 1'b0;
      f3.fetch_ready = 1'b1;
      repeat (8) tick();
      checks++;
      if ({f1.fq_count, f1.imem_en} !== {3'd4, 1'b0}) begin
         errors++;
         $display("FAIL mid_full count=%0d en=%b expected 4/0", f1.fq_count, f1.imem_en);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({f1.fetch_valid, f1.fq_count, f3.fetch_valid, f3.fq_count} !== {1'b0, 3'd0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL mid_cleared v1=%b c1=%0d v3=%b c3=%0d expected all 0",
                  f1.fetch_valid, f1.fq_count, f3.fetch_valid, f3.fq_count);
      end
      #1;
      checks++;
      if ({f1.imem_en, f1.imem_addr, f3.imem_addr} !== {1'b1, 13'h000, 13'h400}) begin
         errors++;
         $display("FAIL mid_issue en=%b addr1=%h addr3=%h expected 1/000/400",
                  f1.imem_en, f1.imem_addr, f3.imem_addr);
      end
      f1.fetch_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (f3.fetch_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale3[%0d] valid=%b pc=%h expected 0", k, f3.fetch_valid, f3.fetch_pc);
         end
      end
      tick();
      checks++;
      if ({f3.fetch_valid, f3.fetch_pc, f1.fetch_valid, f1.fetch_pc, f1.fetch_instr}
          !== {1'b1, 32'h1000, 1'b1, 32'h8, 32'h1B}) begin
         errors++;
         $display("FAIL mid_restart v3=%b pc3=%h v1=%b pc1=%h instr1=%h expected 1/1000/1/8/1b",
                  f3.fetch_valid, f3.fetch_pc, f1.fetch_valid, f1.fetch_pc, f1.fetch_instr);
      end
   endtask

   initial begin
      logic [31:0] next_pc;
      test_reset();
      test_stream(next_pc);
      test_backpressure(next_pc);
      test_redirect();
      test_back_to_back();
      test_redirect_pop();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Decoupled instruction-fetch front end for the multi-cycle and pipelined RV32 cores; successor to the single-cycle core's combinational PC/IMEM path.
- Issues one word read per cycle to a synchronous instruction memory of configurable read latency.
- Tags responses and buffers them in a fetch queue that drives a valid/ready interface toward decode.
- Supports redirect (branch/jump/reset vector), squashing all wrong-path fetches in flight and in the queue.

Parameters:
XLEN, 32, PC width in bits
RESET_PC, 32'h0000_0000, fetch address after reset (word-aligned)
IMEM_AW, 13, instruction-memory word-address width
IMEM_LATENCY, 1, cycles from imem_en to valid imem_rdata (1..4)
FQ_DEPTH, 4, fetch-queue entries (power of two, >=2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
imem_en  output  1  read request this cycle
imem_addr  output  IMEM_AW  word address = req_pc[IMEM_AW+1:2]
imem_rdata  input  32  read data, valid exactly IMEM_LATENCY cycles after the matching imem_en
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
fetch_valid  output  1  queue head valid
fetch_pc  output  XLEN  PC of head instruction
fetch_instr  output  32  head instruction word
fetch_ready  input  1  consumer accepts head
fq_count  output  $clog2(FQ_DEPTH+1)  current queue occupancy

Behaviour:
- Interface: one clock `clk`, synchronous active-high reset `rst`; all state updates on posedge clk.
- Reset: req_pc=RESET_PC, in-flight shift register cleared, queue empty. Outputs: fetch_valid=0, fq_count=0, imem_en=0, fetch_pc/fetch_instr=0.
- Issue:
  - imem_en = !rst && !redirect_valid && (fq_count + inflight) < FQ_DEPTH.
  - inflight = number of valid in-flight stages; both terms are registered values. A same-cycle pop grants no credit.
  - On issue: req_pc <= req_pc+4, wrapping modulo 2^XLEN.
  - imem_addr continuously shows req_pc[IMEM_AW+1:2]; upper PC bits alias.
- In-flight tracking:
  - IMEM_LATENCY-stage shift register of {valid, pc}; stage 0 loads {imem_en, req_pc}.
  - When the last stage is valid, {pc, imem_rdata} is pushed into the queue at that clock edge.
- Queue:
  - Circular FIFO, show-ahead: head drives fetch_pc/fetch_instr while fetch_valid=(fq_count!=0).
  - Pop when fetch_valid && fetch_ready.
  - Push and pop in the same cycle are allowed; fq_count is unchanged.
  - Overflow cannot occur because of credit gating; a push when full is a design error (assertion).
  - Pointers wrap modulo FQ_DEPTH.
- Latency: first cycle with rst=0 is T0, and imem_en=1 at T0. The instruction is visible (fetch_valid=1) at T0+IMEM_LATENCY+1.
- Throughput: sustains 1 instr/cycle when fetch_ready is held high and FQ_DEPTH >= IMEM_LATENCY+2. Otherwise it is credit-limited, with no loss or duplication.
- Redirect, cycle R:
  - No issue in R.
  - At the end of R: all in-flight valid bits are cleared, the queue is emptied (a pop in R is ignored), and req_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - R+1: fetch_valid=0, imem_en=1 at the new PC (credit permitting).
  - Back-to-back redirects: the last one wins; no wrong-path word is ever emitted.
- Priority: rst > redirect_valid > push/pop/issue.
- Reset mid-operation: identical to the reset state on the next cycle. Any imem_rdata returning afterward is ignored.
- fetch_pc/fetch_instr are don't-care when fetch_valid=0 (zero after reset only).

Test Plan:
1. L=1, DEPTH=4, RESET_PC=0, IMEM model rdata=addr*4+0x13, fetch_ready=1, rst released at T0 -> fetch_valid first high at T0+2 with pc 0x0/instr 0x13, then pc 0x4, 0x8... one per cycle, no bubbles.
2. fetch_ready=0 for 10 cycles -> fq_count saturates at 4, imem_en=0 once fq_count+inflight=4. Raise ready -> pcs continue contiguous, none lost or repeated.
3. Queue holding 3 entries, 1 in flight, redirect_valid with redirect_pc=0x100 -> next cycle fetch_valid=0, fq_count=0. Next emitted pc is 0x100 at R+1+L+1; old pcs never appear.
4. L=3, redirects to 0x200 and 0x300 on consecutive cycles -> only the stream 0x300, 0x304... is emitted, with no 0x200-stream words.
5. redirect_pc=0x102 coinciding with fetch_valid&&fetch_ready -> the popped entry is discarded with no duplicate, and the first new fetch_pc=0x100.
6. Queue full, rst pulsed 1 cycle -> next cycle fetch_valid=0, fq_count=0, imem_en=1 with imem_addr=RESET_PC>>2. Stale imem_rdata is not enqueued.
